bch_enc_ctrl: RTL and testbench

Frame sequencer for the bch_encoder shift-register datapath (n=255, k=191).
- Accepts one K-bit message per valid/ready handshake and holds it stable on the encoder's msg input.
- Clears the encoder with a one-cycle rst pulse, counts K+1 shift/parity cycles, then captures the finished N-bit codeword into an output register presented with valid/ready.
- The output register is decoupled from the encoder, so the next frame encodes while the previous codeword waits for downstream.

---
 rtl/bch_pkg.sv | 16 +
 rtl/bch_enc_ctrl.sv | 145 ++++++++++++++
 tb/tb_bch_enc_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared constants and state encoding for the BCH(255,191) encoder frame sequencer.
package bch_pkg;

    localparam int BCH_N   = 255;
    localparam int BCH_K   = 191;
    localparam int BCH_PAR = BCH_N - BCH_K;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        CAP  = 2'd3
    } state_t;

endpackage

// File: rtl/bch_enc_ctrl.sv
// Frame sequencer for the bch_encoder shift-register datapath: accept, clear, shift K+1 steps, capture.
// Optional macro BCH_CTRL_SELFCHECK_EN adds a sticky sys_err flag for a corrupt systematic part.
module bch_enc_ctrl #(
    parameter int N     = bch_pkg::BCH_N,
    parameter int K     = bch_pkg::BCH_K,
    parameter int CNT_W = bch_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [K-1:0]    in_msg,
    output logic            enc_rst,
    output logic [K-1:0]    enc_msg,
    input  logic [N-1:0]    enc_codeword,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_codeword,
    output logic            busy,
    output logic [15:0]     frame_cnt
`ifdef BCH_CTRL_SELFCHECK_EN
    ,
    output logic            sys_err
`endif
);
    import bch_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               enc_rst_r;
    logic [K-1:0]       enc_msg_r;
    logic               out_valid_r;
    logic [N-1:0]       out_codeword_r;
    logic [15:0]        frame_cnt_r;
    logic               accept_s;
    logic               out_take_s;
    logic               cap_load_s;

    // Handshake qualifiers; a CAP load may coincide with downstream taking the old codeword.
    always_comb begin
        accept_s   = in_valid && in_ready;
        out_take_s = out_valid_r && out_ready;
        cap_load_s = (state_r == CAP) && (!out_valid_r || out_ready);
    end

    assign in_ready     = (state_r == IDLE) && !rst;
    assign busy         = (state_r != IDLE);
    assign enc_rst      = enc_rst_r;
    assign enc_msg      = enc_msg_r;
    assign out_valid    = out_valid_r;
    assign out_codeword = out_codeword_r;
    assign frame_cnt    = frame_cnt_r;

    // Frame sequencer FSM: holds the encoder in reset except while a frame is shifting or captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            enc_rst_r <= 1'b1;
            enc_msg_r <= {K{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    enc_rst_r <= 1'b1;
                    if (accept_s) begin
                        enc_msg_r <= in_msg;
                        state_r   <= CLR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CLR: begin
                    enc_rst_r <= 1'b0;
                    cnt_r     <= {CNT_W{1'b0}};
                    state_r   <= RUN;
                end
                RUN: begin
                    enc_rst_r <= 1'b0;
                    cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= CAP;
                    end else begin
                        state_r <= RUN;
                    end
                end
                CAP: begin
                    // Encoder sits idle here and keeps its final codeword while we stall.
                    if (cap_load_s) begin
                        enc_rst_r <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        enc_rst_r <= 1'b0;
                        state_r   <= CAP;
                    end
                end
                default: begin
                    enc_rst_r <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Output codeword register and delivered-frame counter, decoupled from the encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r    <= 1'b0;
            out_codeword_r <= {N{1'b0}};
            frame_cnt_r    <= 16'h0000;
        end else begin
            if (cap_load_s) begin
                out_codeword_r <= enc_codeword;
                out_valid_r    <= 1'b1;
            end else if (out_take_s) begin
                out_valid_r    <= 1'b0;
            end else begin
                out_valid_r    <= out_valid_r;
            end
            if (out_take_s) begin
                frame_cnt_r <= frame_cnt_r + 16'h0001;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

`ifdef BCH_CTRL_SELFCHECK_EN
    logic sys_err_r;
    assign sys_err = sys_err_r;

    // Sticky flag: the systematic bits of the finished codeword must equal the held message.
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_err_r <= 1'b0;
        end else if ((state_r == CAP) && (enc_codeword[N-1:N-K] != enc_msg_r)) begin
            sys_err_r <= 1'b1;
        end else begin
            sys_err_r <= sys_err_r;
        end
    end
`endif

endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Bench for bch_enc_ctrl with a behavioural stand-in encoder and a polynomial-division golden model.
module tb_bch_enc_ctrl;
    import bch_pkg::*;

    localparam int N = BCH_N;
    localparam int K = BCH_K;
    localparam int P = BCH_PAR;
    // Stand-in degree-64 generator; the controller is agnostic to the actual polynomial.
    localparam logic [P-1:0] GEN = 64'h42F0_E1EB_A9EA_3693;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [K-1:0] in_msg = '0;
    logic in_ready, enc_rst, out_valid, busy;
    logic [K-1:0] enc_msg;
    logic [N-1:0] enc_codeword, out_codeword;
    logic [15:0] frame_cnt;
`ifdef BCH_CTRL_SELFCHECK_EN
    logic sys_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_fc = 16'h0000;

    always #5 clk = ~clk;

    bch_enc_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .enc_rst(enc_rst), .enc_msg(enc_msg), .enc_codeword(enc_codeword),
        .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
        .busy(busy), .frame_cnt(frame_cnt)
`ifdef BCH_CTRL_SELFCHECK_EN
        , .sys_err(sys_err)
`endif
    );

    // Cycle-level encoder environment: clear on rst, then one message bit per step, parity at step K.
    logic [P-1:0] m_lfsr = '0;
    logic [K-1:0] m_sh = '0;
    logic [K-1:0] m_data = '0;
    logic [N-1:0] m_out = '0;
    logic [N-1:0] flip_mask = '0;
    int m_step = 0;
    always @(posedge clk) begin
        if (enc_rst) begin
            m_lfsr <= '0;
            m_data <= '0;
            m_sh   <= enc_msg;
            m_step <= 0;
        end else if (m_step < K) begin
            m_lfsr <= {m_lfsr[P-2:0], 1'b0} ^ ((m_sh[K-1] ^ m_lfsr[P-1]) ? GEN : {P{1'b0}});
            m_data <= {m_data[K-2:0], m_sh[K-1]};
            m_sh   <= {m_sh[K-2:0], 1'b0};
            m_step <= m_step + 1;
        end else if (m_step == K) begin
            m_out  <= {m_data, m_lfsr};
            m_step <= m_step + 1;
        end
    end
    assign enc_codeword = m_out ^ flip_mask;

    // Golden codeword: message followed by remainder of m(x)*x^64 mod g(x), by long division.
    function automatic logic [N-1:0] golden(input logic [K-1:0] m);
        logic [N-1:0] v;
        v = {m, {P{1'b0}}};
        for (int i = 0; i < K; i++) begin
            if (v[N-1]) v = v ^ {1'b1, GEN, {(N-P-1){1'b0}}};
            v = v << 1;
        end
        return {m, v[N-1:N-P]};
    endfunction

    function automatic logic [K-1:0] rand_msg();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r = {r[159:0], $urandom()};
        return r[K-1:0];
    endfunction

    task automatic send(input logic [K-1:0] m, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_msg   = m;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1 edges++;
        end while (!out_valid && edges < 400);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (enc_rst !== 1'b1) begin errors++; $display("FAIL reset_enc_rst got %0b exp 1", enc_rst); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt got %h exp 0", frame_cnt); end
        checks++; if (out_codeword !== '0 || enc_msg !== '0) begin errors++; $display("FAIL reset_regs got cw %h msg %h exp 0", out_codeword, enc_msg); end
`ifdef BCH_CTRL_SELFCHECK_EN
        checks++; if (sys_err !== 1'b0) begin errors++; $display("FAIL reset_sys_err got %0b exp 0", sys_err); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b exp 1", in_ready); end
        checks++; if (busy !== 1'b0 || enc_rst !== 1'b1) begin errors++; $display("FAIL idle_state got busy %0b enc_rst %0b exp 0 1", busy, enc_rst); end
        exp_fc = 16'h0000;
    endtask

    task automatic run_frame(input string tag, input logic [K-1:0] m);
        bit ok;
        int e;
        logic [N-1:0] g;
        g = golden(m);
        out_ready = 1'b1;
        send(m, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept got in_ready 0 exp 1", tag); end
        wait_out(e);
        checks++; if (e !== K + 3) begin errors++; $display("FAIL %s_latency got %0d exp %0d", tag, e, K + 3); end
        checks++; if (out_codeword !== g) begin errors++; $display("FAIL %s_codeword got %h exp %h", tag, out_codeword, g); end
        @(posedge clk);
        #1 exp_fc = exp_fc + 16'h0001;
        checks++; if (frame_cnt !== exp_fc || out_valid !== 1'b0) begin errors++; $display("FAIL %s_frame_cnt got %h/%0b exp %h/0", tag, frame_cnt, out_valid, exp_fc); end
    endtask

    task automatic test_single();
        logic [K-1:0] m;
        m = '0;
        m[0] = 1'b1;
        run_frame("single", m);
        checks++; if (out_codeword[N-1:P] !== m || enc_msg !== m) begin errors++; $display("FAIL single_systematic got %h exp %h", out_codeword[N-1:P], m); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_frame("random", rand_msg());
    endtask

    task automatic test_back_to_back();
        bit ok_a, ok_b, stable;
        int e;
        logic [K-1:0] a, b;
        a = rand_msg();
        b = rand_msg();
        out_ready = 1'b0;
        send(a, ok_a);
        wait_out(e);
        checks++; if (e !== K + 3 || out_codeword !== golden(a)) begin errors++; $display("FAIL bp_frame_a got lat %0d cw %h exp %0d %h", e, out_codeword, K + 3, golden(a)); end
        send(b, ok_b);
        checks++; if (!ok_a || !ok_b) begin errors++; $display("FAIL bp_accept got %0b%0b exp 11", ok_a, ok_b); end
        stable = 1'b1;
        for (int i = 0; i < K + 8; i++) begin
            @(posedge clk);
            #1 if (out_codeword !== golden(a) || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold_a got unstable codeword exp held %h", golden(a)); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || enc_msg !== b) begin errors++; $display("FAIL bp_stall got in_ready %0b busy %0b exp 0 1", in_ready, busy); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_fc = exp_fc + 16'h0001;
        checks++; if (out_valid !== 1'b1 || out_codeword !== golden(b)) begin errors++; $display("FAIL bp_load_b got %0b %h exp 1 %h", out_valid, out_codeword, golden(b)); end
        checks++; if (frame_cnt !== exp_fc || busy !== 1'b0) begin errors++; $display("FAIL bp_count_a got %h busy %0b exp %h 0", frame_cnt, busy, exp_fc); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 exp_fc = exp_fc + 16'h0001;
        checks++; if (frame_cnt !== exp_fc || out_valid !== 1'b0) begin errors++; $display("FAIL bp_count_b got %h %0b exp %h 0", frame_cnt, out_valid, exp_fc); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int e;
        out_ready = 1'b0;
        send(rand_msg(), ok);
        wait_out(e);
        send(rand_msg(), ok);
        repeat (101) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got busy %0b ov %0b exp 1 1", busy, out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 exp_fc = 16'h0000;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || enc_rst !== 1'b1) begin errors++; $display("FAIL abort_state got ov %0b busy %0b enc_rst %0b exp 0 0 1", out_valid, busy, enc_rst); end
        checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL abort_frame_cnt got %h exp %h", frame_cnt, exp_fc); end
        run_frame("after_abort", {K{1'b1}});
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.frame_cnt_r = 16'hFFFE;
        #1 release dut.frame_cnt_r;
        exp_fc = 16'hFFFE;
        checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL wrap_preload got %h exp %h", frame_cnt, exp_fc); end
        run_frame("wrap_ffff", rand_msg());
        run_frame("wrap_0000", rand_msg());
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", frame_cnt); end
    endtask

`ifdef BCH_CTRL_SELFCHECK_EN
    task automatic test_selfcheck();
        logic [N-1:0] one;
        one = '0;
        one[0] = 1'b1;
        checks++; if (sys_err !== 1'b0) begin errors++; $display("FAIL selfcheck_clean got %0b exp 0", sys_err); end
        flip_mask = one << 200;
        run_frame("selfcheck", rand_msg());
        flip_mask = '0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (sys_err !== 1'b1) begin errors++; $display("FAIL selfcheck_sticky got %0b exp 1", sys_err); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_fc = 16'h0000;
        checks++; if (sys_err !== 1'b0) begin errors++; $display("FAIL selfcheck_clear got %0b exp 0", sys_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_wrap();
`ifdef BCH_CTRL_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
